if_id_pipe_ctrl: RTL and testbench

- Front-end pipeline register block for the 5-stage RISC-V core.
- Consumes the load-use hazard controls (PCWrite, Stall, NoOp) and the ID-stage branch flush.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control-bundle register, and applies holds, flushes and bubbles to them.
- Keeps saturating stall and flush event counters for lab performance reporting.

---
 rtl/if_id_pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_if_id_pipe_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// if_id_pipe_ctrl
// Front-end pipeline register block for the 5-stage RISC-V core. It owns the
// fetch PC, the IF/ID pipeline register and the ID/EX control-bundle register.
// It applies load-use holds, ID-stage branch flushes and EX bubbles to them.
// It also keeps saturating stall/flush event counters for performance reports.
//
// Ports:
//   clk_i            core clock, all state updates on the rising edge
//   rst_i            synchronous active-low reset
//   PCWrite_i        1 = PC may advance, 0 = hold PC
//   Stall_i          1 = hold IF/ID contents
//   NoOp_i           1 = inject a bubble into the ID/EX control register
//   Flush_i          branch/jump taken in ID, squash the fetched instruction
//   Branch_target_i  redirect PC used when a flush is honored
//   instr_i          instruction-memory read data for the current pc_o
//   ctrl_i           ID-stage decoded control bundle
//   pc_o             current fetch PC (instruction-memory address)
//   IF_ID_pc_o       PC of the instruction held in IF/ID
//   IF_ID_instr_o    instruction held in IF/ID
//   IF_ID_valid_o    IF/ID holds a real (non-squashed) instruction
//   ID_EX_ctrl_o     registered control bundle into EX
//   stall_cnt_o      cycles with Stall_i=1 since reset (saturating)
//   flush_cnt_o      honored flushes since reset (saturating)
// -----------------------------------------------------------------------------
module if_id_pipe_ctrl #(
  parameter int                 XLEN      = 32,
  parameter int                 CTRL_W    = 8,
  parameter logic [XLEN-1:0]    RESET_PC  = 32'h00000000,
  parameter logic [XLEN-1:0]    NOP_INSTR = 32'h00000013,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              PCWrite_i,
  input  logic              Stall_i,
  input  logic              NoOp_i,
  input  logic              Flush_i,
  input  logic [XLEN-1:0]   Branch_target_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   IF_ID_pc_o,
  output logic [XLEN-1:0]   IF_ID_instr_o,
  output logic              IF_ID_valid_o,
  output logic [CTRL_W-1:0] ID_EX_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   if_id_pc_r;
  logic [XLEN-1:0]   if_id_instr_r;
  logic              if_id_valid_r;
  logic [CTRL_W-1:0] id_ex_ctrl_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic              flush_ok_s;
  logic [XLEN-1:0]   pc_next_s;

  // A stalled branch still has unresolved operands, so its flush is ignored
  // and the branch is re-evaluated once the stall drops.
  always_comb begin
    flush_ok_s = Flush_i & ~Stall_i;
  end

  // Next fetch PC: redirect beats hold, hold beats sequential advance.
  // The +4 wraps naturally modulo 2^XLEN.
  always_comb begin
    pc_next_s = pc_r;
    if (flush_ok_s) begin
      pc_next_s = Branch_target_i;
    end else if (!PCWrite_i) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
  end

  // PC register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID register: stall holds, honored flush squashes to a NOP, else load.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if_id_pc_r    <= {XLEN{1'b0}};
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
    end else if (Stall_i) begin
      if_id_pc_r    <= if_id_pc_r;
      if_id_instr_r <= if_id_instr_r;
      if_id_valid_r <= if_id_valid_r;
    end else if (flush_ok_s) begin
      if_id_pc_r    <= {XLEN{1'b0}};
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
    end else begin
      if_id_pc_r    <= pc_r;
      if_id_instr_r <= instr_i;
      if_id_valid_r <= 1'b1;
    end
  end

  // ID/EX control register: a bubble clears every control bit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      id_ex_ctrl_r <= {CTRL_W{1'b0}};
    end else if (NoOp_i) begin
      id_ex_ctrl_r <= {CTRL_W{1'b0}};
    end else begin
      id_ex_ctrl_r <= ctrl_i;
    end
  end

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (Stall_i && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_ok_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign pc_o          = pc_r;
  assign IF_ID_pc_o    = if_id_pc_r;
  assign IF_ID_instr_o = if_id_instr_r;
  assign IF_ID_valid_o = if_id_valid_r;
  assign ID_EX_ctrl_o  = id_ex_ctrl_r;
  assign stall_cnt_o   = stall_cnt_r;
  assign flush_cnt_o   = flush_cnt_r;

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe_ctrl
// Scoreboard bench for if_id_pipe_ctrl (instantiated with CNT_W=4 so counter
// saturation is reachable). The driver applies one input vector per cycle,
// advances a behavioural model of the front end and queues the expected
// outputs; a monitor pops and compares after every rising edge. A few absolute
// checks from the directed scenarios are made directly by the driver.
// -----------------------------------------------------------------------------
module tb_if_id_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        PCWrite_i = 1'b0;
  logic        Stall_i = 1'b0;
  logic        NoOp_i = 1'b0;
  logic        Flush_i = 1'b0;
  logic [31:0] Branch_target_i = 32'h0;
  logic [31:0] instr_i = 32'h0;
  logic [7:0]  ctrl_i = 8'h0;
  logic [31:0] pc_o, IF_ID_pc_o, IF_ID_instr_o;
  logic        IF_ID_valid_o;
  logic [7:0]  ID_EX_ctrl_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  if_id_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .PCWrite_i(PCWrite_i), .Stall_i(Stall_i),
    .NoOp_i(NoOp_i), .Flush_i(Flush_i), .Branch_target_i(Branch_target_i),
    .instr_i(instr_i), .ctrl_i(ctrl_i), .pc_o(pc_o), .IF_ID_pc_o(IF_ID_pc_o),
    .IF_ID_instr_o(IF_ID_instr_o), .IF_ID_valid_o(IF_ID_valid_o),
    .ID_EX_ctrl_o(ID_EX_ctrl_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [7:0]  ctrl;
    int          stall_cnt;
    int          flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_ifid_pc;
  logic [31:0] m_ifid_instr;
  logic        m_ifid_valid;
  logic [7:0]  m_ctrl;
  int          m_stall;
  int          m_flush;

  int n_vec  = 0;
  int n_miss = 0;

  // instruction memory contents: a distinct word per address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  // One cycle: drive inputs, advance the model, queue the expected outputs.
  task automatic apply(input logic rst, input logic pcw, input logic stall,
                       input logic noop, input logic flush,
                       input logic [31:0] tgt, input logic [7:0] ctrl);
    logic fok;
    logic [31:0] instr;
    exp_t e;
    instr = imem(m_pc);
    rst_i = rst; PCWrite_i = pcw; Stall_i = stall; NoOp_i = noop;
    Flush_i = flush; Branch_target_i = tgt; ctrl_i = ctrl; instr_i = instr;
    if (!rst) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
      m_ctrl = 8'h0; m_stall = 0; m_flush = 0;
    end else begin
      fok = flush && !stall;
      if (!stall) begin
        m_ifid_valid = !fok;
        m_ifid_pc    = fok ? 32'h0 : m_pc;
        m_ifid_instr = fok ? NOP : instr;
      end
      if (fok)      m_pc = tgt;
      else if (pcw) m_pc = m_pc + 32'd4;
      m_ctrl = noop ? 8'h0 : ctrl;
      if (stall) m_stall = (m_stall + 1 > CNT_SAT) ? CNT_SAT : m_stall + 1;
      if (fok)   m_flush = (m_flush + 1 > CNT_SAT) ? CNT_SAT : m_flush + 1;
    end
    e.pc = m_pc; e.ifid_pc = m_ifid_pc; e.ifid_instr = m_ifid_instr;
    e.ifid_valid = m_ifid_valid; e.ctrl = m_ctrl;
    e.stall_cnt = m_stall; e.flush_cnt = m_flush;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic free_cycle();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'($urandom_range(1, 255)));
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each edge.
  always @(posedge clk_i) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc_o",          pc_o,          mon_e.pc);
      check("IF_ID_pc_o",    IF_ID_pc_o,    mon_e.ifid_pc);
      check("IF_ID_instr_o", IF_ID_instr_o, mon_e.ifid_instr);
      check("IF_ID_valid_o", {31'h0, IF_ID_valid_o}, {31'h0, mon_e.ifid_valid});
      check("ID_EX_ctrl_o",  {24'h0, ID_EX_ctrl_o}, {24'h0, mon_e.ctrl});
      check("stall_cnt_o",   {28'h0, stall_cnt_o},  mon_e.stall_cnt);
      check("flush_cnt_o",   {28'h0, flush_cnt_o},  mon_e.flush_cnt);
    end
  end

  initial begin
    m_pc = 32'h0;
    // reset
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'hAA);
    check("reset_pc", pc_o, 32'h0);
    check("reset_instr", IF_ID_instr_o, NOP);
    // three free-running fetches
    for (int i = 0; i < 3; i++) free_cycle();
    check("free_pc", pc_o, 32'd12);
    check("free_ifid_instr", IF_ID_instr_o, imem(32'd8));
    // load-use hold
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h77);
    check("ldu_pc", pc_o, 32'd12);
    check("ldu_ctrl", {24'h0, ID_EX_ctrl_o}, 32'h0);
    check("ldu_stall_cnt", {28'h0, stall_cnt_o}, 32'd1);
    free_cycle();
    check("ldu_resume_pc", pc_o, 32'd16);
    // honored flush
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 8'h11);
    check("flush_pc", pc_o, 32'h40);
    check("flush_valid", {31'h0, IF_ID_valid_o}, 32'h0);
    check("flush_cnt", {28'h0, flush_cnt_o}, 32'd1);
    free_cycle();
    check("flush_fetch", IF_ID_instr_o, imem(32'h40));
    // flush while stalled is ignored, then taken
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 8'h22);
    check("stflush_pc", pc_o, 32'h44);
    check("stflush_cnt", {28'h0, flush_cnt_o}, 32'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 8'h33);
    check("stflush_taken", pc_o, 32'h80);
    check("stflush_cnt2", {28'h0, flush_cnt_o}, 32'd2);
    // reset mid-stall
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h44);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h44);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 8'h44);
    check("rst_stall_cnt", {28'h0, stall_cnt_o}, 32'd0);
    check("rst_pc", pc_o, 32'h0);
    free_cycle();
    check("rst_first_fetch", IF_ID_instr_o, imem(32'h0));
    // stall counter saturation
    for (int i = 0; i < 20; i++) apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h5);
    check("stall_sat", {28'h0, stall_cnt_o}, 32'd15);
    // PC wrap
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 8'h6);
    free_cycle();
    check("pc_wrap", pc_o, 32'h0);
    check("pc_wrap_ifid", IF_ID_pc_o, 32'hFFFFFFFC);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
            8'($urandom));
    end
    repeat (3) @(posedge clk_i);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
